// File: rtl/dmem_pkg.sv
// Shared types and constants for the multi-cycle data-memory responder.
// Optional build macro used by dmem_responder: DMEM_RESP_ALIGN_CHK_EN.
package dmem_pkg;

    localparam int unsigned DATA_W      = 16;
    localparam int unsigned ADDR_W      = 16;
    localparam int unsigned DEF_LATENCY = 4;
    localparam int unsigned DEF_IDX_W   = 12;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    // Down-counter width: enough to hold LATENCY-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned latency);
        return (latency <= 1) ? 1 : $clog2(latency);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port 2^IDX_W x 16 word array: synchronous write, registered read.
// The read register only updates on an enabled read, so it holds the last load.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int unsigned IDX_W = DEF_IDX_W
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_en,
    input  logic              i_we,
    input  logic [IDX_W-1:0]  i_idx,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    localparam int unsigned DEPTH = 2 ** IDX_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // Contents are deliberately not reset.
    always_ff @(posedge i_clk) begin
        if (i_en && i_we) begin
            r_mem[i_idx] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rdata <= '0;
        end else if (i_en && !i_we) begin
            r_rdata <= r_mem[i_idx];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// Target side of the CPU load/store interface with a fixed, parameterised latency.
// Build macro DMEM_RESP_ALIGN_CHK_EN enables misaligned-access detection on req_addr[0].
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned LATENCY = DEF_LATENCY,
    parameter int unsigned IDX_W   = DEF_IDX_W
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req_en,
    input  logic              i_req_wr,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [DATA_W-1:0] i_req_wdata,
    output logic              o_busy,
    output logic              o_resp_valid,
    output logic [DATA_W-1:0] o_resp_rdata,
    output logic              o_resp_err
);

    localparam int unsigned CNT_W = cnt_width(LATENCY);

    state_e             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_busy;
    logic               r_resp_valid;
    logic               r_resp_err;
    logic               r_wr;
    logic               r_mis;
    logic [IDX_W-1:0]   r_idx;
    logic [DATA_W-1:0]  r_wdata;

    state_e             w_state_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               w_accept;
    logic               w_access;
    logic               w_req_mis;
    logic               w_mem_en;
    logic               w_unused_addr;

`ifdef DMEM_RESP_ALIGN_CHK_EN
    assign w_req_mis     = i_req_addr[0];
    assign w_unused_addr = ^i_req_addr[ADDR_W-1:IDX_W+1];
`else
    assign w_req_mis     = 1'b0;
    assign w_unused_addr = ^{i_req_addr[ADDR_W-1:IDX_W+1], i_req_addr[0]};
`endif

    // Next state, counter and access strobe.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        w_access    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_req_en) begin
                    w_accept    = 1'b1;
                    w_cnt_nxt   = CNT_W'(LATENCY - 1);
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end else begin
                    w_access    = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_busy       <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_wr         <= 1'b0;
            r_mis        <= 1'b0;
            r_idx        <= '0;
            r_wdata      <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_busy       <= (w_state_nxt == ST_WAIT);
            r_resp_valid <= w_access;
            r_resp_err   <= w_access & r_mis;
            if (w_accept) begin
                r_wr    <= i_req_wr;
                r_mis   <= w_req_mis;
                r_idx   <= i_req_addr[IDX_W:1];
                r_wdata <= i_req_wdata;
            end
        end
    end

    // A reset on the access edge must suppress the write.
    assign w_mem_en = w_access & ~r_mis & ~i_rst;

    dmem_array #(
        .IDX_W (IDX_W)
    ) u_array (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_en    (w_mem_en),
        .i_we    (r_wr),
        .i_idx   (r_idx),
        .i_wdata (r_wdata),
        .o_rdata (o_resp_rdata)
    );

    assign o_busy       = r_busy;
    assign o_resp_valid = r_resp_valid;
    assign o_resp_err   = r_resp_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed and randomized bench for dmem_responder against a word-array reference model.
module tb_dmem_responder;

    localparam int unsigned LAT   = 4;
    localparam int unsigned IDXW  = 12;
    localparam int unsigned IMASK = (1 << IDXW) - 1;

`ifdef DMEM_RESP_ALIGN_CHK_EN
    localparam bit ALIGN_CHK = 1'b1;
`else
    localparam bit ALIGN_CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req_en;
    logic        req_wr;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        busy;
    logic        resp_valid;
    logic [15:0] resp_rdata;
    logic        resp_err;

    int          total = 0;
    int          bad   = 0;

    logic [15:0] model_mem [int];
    logic [15:0] exp_rdata;
    bit          exp_known;

    always #5 clk = ~clk;

    dmem_responder #(
        .LATENCY (LAT),
        .IDX_W   (IDXW)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_req_en     (req_en),
        .i_req_wr     (req_wr),
        .i_req_addr   (req_addr),
        .i_req_wdata  (req_wdata),
        .o_busy       (busy),
        .o_resp_valid (resp_valid),
        .o_resp_rdata (resp_rdata),
        .o_resp_err   (resp_err)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction; optionally drives a conflicting store while busy.
    task automatic xact(input logic wr, input logic [15:0] addr, input logic [15:0] wdata,
                        input bit poke);
        int idx;
        bit mis;
        idx = (int'(addr) >> 1) & IMASK;
        mis = ALIGN_CHK && addr[0];
        req_en = 1'b1; req_wr = wr; req_addr = addr; req_wdata = wdata;
        for (int k = 1; k <= int'(LAT); k++) begin
            tick();
            if (k == 1) begin
                req_en = poke; req_wr = 1'b1; req_addr = 16'h0020; req_wdata = 16'h1234;
            end
            chk("busy_in_flight", 16'(busy), 16'h1);
            chk("no_early_valid", 16'(resp_valid), 16'h0);
        end
        tick();
        req_en = 1'b0;
        if (!mis) begin
            if (wr) begin
                model_mem[idx] = wdata;
            end else begin
                exp_known = model_mem.exists(idx);
                if (exp_known) exp_rdata = model_mem[idx];
            end
        end
        chk("busy_done", 16'(busy), 16'h0);
        chk("resp_valid", 16'(resp_valid), 16'h1);
        chk("resp_err", 16'(resp_err), 16'(mis));
        if (exp_known) chk("resp_rdata", resp_rdata, exp_rdata);
    endtask

    initial begin
        logic [15:0] a;
        rst = 1'b1; req_en = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0;
        exp_rdata = 16'h0; exp_known = 1'b1;
        tick(); tick();
        chk("rst_busy", 16'(busy), 16'h0);
        chk("rst_valid", 16'(resp_valid), 16'h0);
        chk("rst_rdata", resp_rdata, 16'h0);
        chk("rst_err", 16'(resp_err), 16'h0);
        rst = 1'b0;
        tick();

        // Store then back-to-back load in the resp_valid cycle.
        xact(1'b1, 16'h0010, 16'hBEEF, 1'b0);
        xact(1'b0, 16'h0010, 16'h0000, 1'b0);
        chk("load_beef", resp_rdata, 16'hBEEF);

        // Store issued while busy must be dropped.
        xact(1'b1, 16'h0020, 16'h0202, 1'b0);
        xact(1'b0, 16'h0010, 16'h0000, 1'b1);
        tick();
        xact(1'b0, 16'h0020, 16'h0000, 1'b0);
        chk("ignored_store", resp_rdata, 16'h0202);

        // Aliasing of address bits above the index.
        xact(1'b1, 16'h0010, 16'h5A5A, 1'b0);
        xact(1'b0, 16'h0010 + 16'(1 << (IDXW + 1)), 16'h0000, 1'b0);
        chk("alias_load", resp_rdata, 16'h5A5A);

        // Reset two cycles into a store.
        xact(1'b1, 16'h0030, 16'h0101, 1'b0);
        req_en = 1'b1; req_wr = 1'b1; req_addr = 16'h0030; req_wdata = 16'h7777;
        tick();
        req_en = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_rdata = 16'h0; exp_known = 1'b1;
        chk("midrst_busy", 16'(busy), 16'h0);
        chk("midrst_valid", 16'(resp_valid), 16'h0);
        chk("midrst_rdata", resp_rdata, 16'h0);
        chk("midrst_err", 16'(resp_err), 16'h0);
        for (int k = 0; k < int'(LAT) + 2; k++) begin
            tick();
            chk("midrst_no_valid", 16'(resp_valid), 16'h0);
        end

        // Reset wins over a simultaneous request.
        rst = 1'b1; req_en = 1'b1; req_wr = 1'b1; req_addr = 16'h0030; req_wdata = 16'h9999;
        tick();
        rst = 1'b0; req_en = 1'b0;
        chk("rst_req_busy", 16'(busy), 16'h0);
        for (int k = 0; k < int'(LAT) + 1; k++) begin
            tick();
            chk("rst_req_no_valid", 16'(resp_valid), 16'h0);
        end
        xact(1'b0, 16'h0030, 16'h0000, 1'b0);
        chk("after_rst_load", resp_rdata, 16'h0101);

        // Odd address: error flag and no write when checking is enabled.
        xact(1'b1, 16'h0011, 16'hAAAA, 1'b0);
        xact(1'b0, 16'h0010, 16'h0000, 1'b0);
        chk("odd_store_effect", resp_rdata, ALIGN_CHK ? 16'h5A5A : 16'hAAAA);

        // Seed a small working set, then random traffic with aliasing and odd addresses.
        for (int i = 0; i < 8; i++) begin
            xact(1'b1, 16'((32 + i) << 1), 16'($urandom), 1'b0);
        end
        for (int i = 0; i < 40; i++) begin
            a = 16'((int'($urandom_range(0, 7)) << (IDXW + 1)) |
                    ((32 + int'($urandom_range(0, 7))) << 1) | int'($urandom_range(0, 1)));
            xact(1'($urandom_range(0, 1)), a, 16'($urandom), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 2) == 0) tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
